// File: rtl/ipu_track_pkg.sv
// ipu_track_pkg: shared state encoding, register map and field layouts for ipu_track_ctrl
package ipu_track_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOST    = 2'd3
  } track_state_e;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IRQ    = 2'd2;
  localparam logic [31:0] CTRL_WMASK = 32'h0000_0FF3;
  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic [3:0]  lost_n;
    logic [3:0]  acq_n;
    logic [1:0]  rsvd_lo;
    logic        irq_en;
    logic        en;
  } ctrl_t;
  typedef struct packed {
    logic [7:0]   rsvd;
    logic [9:0]   row;
    logic [9:0]   col;
    logic         irq_pend;
    logic         new_pos;
    track_state_e state;
  } status_t;
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
  function automatic logic [3:0] eff_n(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction
endpackage

// File: rtl/ipu_track_if.sv
// ipu_track_if: IPU result stream (valid pulse with presence flag and position)
interface ipu_track_if;
  logic       valid;
  logic       present;
  logic [9:0] row;
  logic [9:0] col;
  modport master (output valid, present, row, col);
  modport slave  (input  valid, present, row, col);
endinterface

// File: rtl/ipu_track_filter.sv
// ipu_track_filter: one-axis position register; EMA with TRACK_FILTER_EN, raw passthrough otherwise
module ipu_track_filter #(
  parameter int FILT_SHIFT = 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       upd,
  input  logic [9:0] din,
  output logic [9:0] pos
);
`ifdef TRACK_FILTER_EN
  localparam int W = 10 + FILT_SHIFT;
  localparam logic signed [W+1:0] MAX_FX = {2'b00, {W{1'b1}}};
  logic [W-1:0] pos_q, pos_d, din_w;
  logic signed [W+1:0] delta, sum;
  always_comb begin
    din_w = W'(din) << FILT_SHIFT;
    delta = $signed({2'b00, din_w}) - $signed({2'b00, pos_q});
    sum   = $signed({2'b00, pos_q}) + (delta >>> FILT_SHIFT);
    pos_d = load ? din_w : upd ? (sum < 0 ? '0 : sum > MAX_FX ? '1 : sum[W-1:0]) : pos_q;
  end
  assign pos = pos_q[W-1:FILT_SHIFT];
`else
  logic [9:0] pos_q, pos_d;
  always_comb pos_d = (load | upd) ? din : pos_q;
  assign pos = pos_q;
`endif
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) pos_q <= '0;
    else pos_q <= pos_d;
endmodule

// File: rtl/ipu_track_ctrl.sv
// ipu_track_ctrl: bus-mapped acquire/track/lost sequencer for IPU results with event interrupt.
// Position smoothing is enabled by defining TRACK_FILTER_EN.
module ipu_track_ctrl
  import ipu_track_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0210,
  parameter logic [3:0]  ACQ_N_RST  = 4'd4,
  parameter logic [3:0]  LOST_N_RST = 4'd8,
  parameter int          FILT_SHIFT = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  ipu_track_if.slave  s,
  output logic        ipu_en,
  output logic        irq,
  input  logic        write_i,
  input  logic        read_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  inout  wire  [31:0] data_o,
  inout  wire         ack_o
);
  track_state_e state_q, state_d;
  ctrl_t ctrl_q, ctrl_d;
  status_t status;
  logic [3:0] hit_q, hit_d, miss_q, miss_d, hit_base, hit_inc, miss_inc;
  logic cause_acq_q, cause_acq_d, cause_lost_q, cause_lost_d, new_pos_q, new_pos_d;
  logic load, upd, acq_set, lost_set, cs, wr, rd, hit;
  logic [1:0] off;
  logic [9:0] row, col;
  logic [31:0] rdata;
  assign off      = addr_i[3:2];
  assign cs       = (addr_i[31:4] == BASE_ADDR[31:4]) && (off != 2'b11);
  assign wr       = write_i & cs;
  assign rd       = read_i & cs;
  assign hit      = s.valid & s.present;
  assign hit_base = (state_q == ST_IDLE) ? 4'd0 : hit_q;
  assign hit_inc  = sat_inc(hit_base);
  assign miss_inc = sat_inc(miss_q);
  // IDLE shares the ACQUIRE path so a sample on the enabling cycle is counted
  always_comb begin
    state_d  = state_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    load     = 1'b0;
    upd      = 1'b0;
    acq_set  = 1'b0;
    lost_set = 1'b0;
    if (!ctrl_q.en) begin
      state_d = ST_IDLE;
      hit_d   = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACQUIRE: begin
          state_d = ST_ACQUIRE;
          miss_d  = '0;
          hit_d   = !s.valid ? hit_base : s.present ? hit_inc : 4'd0;
          if (hit && hit_inc >= eff_n(ctrl_q.acq_n)) begin
            state_d = ST_TRACK;
            hit_d   = '0;
            load    = 1'b1;
            acq_set = 1'b1;
          end
        end
        ST_TRACK: begin
          if (hit) begin
            upd    = 1'b1;
            miss_d = '0;
          end else if (s.valid) begin
            miss_d = miss_inc;
            if (miss_inc >= eff_n(ctrl_q.lost_n)) begin
              state_d  = ST_LOST;
              lost_set = 1'b1;
            end
          end
        end
        default: begin
          if (hit) begin
            state_d = ST_ACQUIRE;
            hit_d   = 4'd1;
            miss_d  = '0;
          end
        end
      endcase
    end
  end
  // Hardware set events take priority over the CPU's read-clear / write-1-clear
  always_comb begin
    ctrl_d       = (wr && off == REG_CTRL) ? ctrl_t'(data_i & CTRL_WMASK) : ctrl_q;
    cause_acq_d  = acq_set | (cause_acq_q & ~(wr && off == REG_IRQ && data_i[0]));
    cause_lost_d = lost_set | (cause_lost_q & ~(wr && off == REG_IRQ && data_i[1]));
    new_pos_d    = load | upd | (new_pos_q & ~(rd && off == REG_STATUS));
    status       = '{rsvd: '0, row: row, col: col, irq_pend: cause_acq_q | cause_lost_q,
                     new_pos: new_pos_q, state: state_q};
    rdata        = (off == REG_CTRL) ? 32'(ctrl_q) :
                   (off == REG_STATUS) ? 32'(status) : {30'b0, cause_lost_q, cause_acq_q};
  end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '{rsvd_hi: '0, lost_n: LOST_N_RST, acq_n: ACQ_N_RST, rsvd_lo: '0,
                        irq_en: 1'b0, en: 1'b0};
      hit_q        <= '0;
      miss_q       <= '0;
      cause_acq_q  <= 1'b0;
      cause_lost_q <= 1'b0;
      new_pos_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      cause_acq_q  <= cause_acq_d;
      cause_lost_q <= cause_lost_d;
      new_pos_q    <= new_pos_d;
    end
  ipu_track_filter #(.FILT_SHIFT(FILT_SHIFT)) u_row (
    .sys_clk(sys_clk), .rst_n(rst_n), .load(load), .upd(upd), .din(s.row), .pos(row)
  );
  ipu_track_filter #(.FILT_SHIFT(FILT_SHIFT)) u_col (
    .sys_clk(sys_clk), .rst_n(rst_n), .load(load), .upd(upd), .din(s.col), .pos(col)
  );
  assign ipu_en = ctrl_q.en;
  assign irq    = (cause_acq_q | cause_lost_q) & ctrl_q.irq_en;
  assign data_o = cs ? rdata : 'z;
  assign ack_o  = cs ? 1'b1 : 1'bz;
endmodule

// File: tb/tb_ipu_track_ctrl.sv
// tb_ipu_track_ctrl: directed checks of register map, tracking sequence, irq and reset.
// Expected filtered position follows TRACK_FILTER_EN.
module tb_ipu_track_ctrl;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic write_i = 1'b0, read_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  logic ipu_en, irq;
  wire [31:0] data_o;
  wire ack_o;
  int n_vec = 0, n_err = 0;
  logic [31:0] rd_v;
  localparam logic [31:0] A_CTRL = 32'h4000_0210;
  localparam logic [31:0] A_STAT = 32'h4000_0214;
  localparam logic [31:0] A_IRQ  = 32'h4000_0218;
  localparam logic [31:0] A_BAD  = 32'h4000_021C;
`ifdef TRACK_FILTER_EN
  localparam logic [31:0] ST_FILT = 32'h001B_8C86;
  localparam logic [31:0] ST_OFF  = 32'h001B_8C80;
`else
  localparam logic [31:0] ST_FILT = 32'h0023_0C86;
  localparam logic [31:0] ST_OFF  = 32'h0023_0C80;
`endif
  ipu_track_if s_if ();
  ipu_track_ctrl dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .s(s_if), .ipu_en(ipu_en), .irq(irq),
    .write_i(write_i), .read_i(read_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .ack_o(ack_o)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    write_i = 1'b1; addr_i = a; data_i = d;
    @(posedge sys_clk); #1;
    write_i = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    read_i = 1'b1; addr_i = a;
    #1 rd_v = data_o;
    chk(tag, rd_v, exp);
    @(posedge sys_clk); #1;
    read_i = 1'b0;
  endtask
  task automatic sample(input logic p, input logic [9:0] r, input logic [9:0] c);
    s_if.valid = 1'b1; s_if.present = p; s_if.row = r; s_if.col = c;
    @(posedge sys_clk); #1;
    s_if.valid = 1'b0;
  endtask
  initial begin
    s_if.valid = 1'b0; s_if.present = 1'b0; s_if.row = '0; s_if.col = '0;
    #12;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_ipu_en", {31'b0, ipu_en}, 32'h0);
    rd_chk("rst_status", A_STAT, 32'h0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0000_0840);
    rst_n = 1'b1;
    bus_wr(A_CTRL, 32'h0000_0843);
    repeat (4) sample(1'b1, 10'd100, 10'd200);
    chk("acq_irq", {31'b0, irq}, 32'h1);
    chk("acq_ipu_en", {31'b0, ipu_en}, 32'h1);
    rd_chk("acq_status", A_STAT, 32'h0019_0C8E);
    rd_chk("acq_status_rc", A_STAT, 32'h0019_0C8A);
    rd_chk("acq_irqreg", A_IRQ, 32'h1);
    repeat (7) sample(1'b0, 10'd0, 10'd0);
    sample(1'b1, 10'd100, 10'd200);
    rd_chk("trk_hold", A_STAT, 32'h0019_0C8E);
    repeat (7) sample(1'b0, 10'd0, 10'd0);
    rd_chk("trk_7miss", A_STAT, 32'h0019_0C8A);
    sample(1'b0, 10'd0, 10'd0);
    rd_chk("lost_status", A_STAT, 32'h0019_0C8B);
    rd_chk("lost_irqreg", A_IRQ, 32'h3);
    bus_wr(A_IRQ, 32'h3);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    rd_chk("w1c_irqreg", A_IRQ, 32'h0);
    sample(1'b1, 10'd100, 10'd200);
    rd_chk("reacq_status", A_STAT, 32'h0019_0C81);
    repeat (2) sample(1'b1, 10'd100, 10'd200);
    s_if.valid = 1'b1; s_if.present = 1'b1; s_if.row = 10'd100; s_if.col = 10'd200;
    write_i = 1'b1; addr_i = A_IRQ; data_i = 32'h1;
    @(posedge sys_clk); #1;
    s_if.valid = 1'b0; write_i = 1'b0;
    chk("setwin_irq", {31'b0, irq}, 32'h1);
    rd_chk("setwin_irqreg", A_IRQ, 32'h1);
    bus_wr(A_IRQ, 32'h1);
    chk("clr_irq", {31'b0, irq}, 32'h0);
    rd_chk("clr_irqreg", A_IRQ, 32'h0);
    sample(1'b1, 10'd140, 10'd200);
    rd_chk("filter_status", A_STAT, ST_FILT);
    bus_wr(A_CTRL, 32'h0000_0842);
    chk("dis_ipu_en", {31'b0, ipu_en}, 32'h0);
    sample(1'b1, 10'd500, 10'd500);
    rd_chk("dis_status", A_STAT, ST_OFF);
    read_i = 1'b1; addr_i = A_BAD;
    #1 n_vec++;
    assert (ack_o !== 1'b1) else begin
      n_err++;
      $error("FAIL bad_addr_ack: observed %b expected z", ack_o);
    end
    addr_i = 32'h4000_0310;
    #1 n_vec++;
    assert (ack_o !== 1'b1) else begin
      n_err++;
      $error("FAIL other_base_ack: observed %b expected z", ack_o);
    end
    addr_i = A_CTRL;
    #1 chk("sel_ack", {31'b0, ack_o}, 32'h1);
    read_i = 1'b0;
    @(posedge sys_clk); #1;
    bus_wr(A_CTRL, 32'h0000_0801);
    sample(1'b1, 10'd7, 10'd9);
    rd_chk("acq0_status", A_STAT, 32'h0001_C09E);
    chk("acq0_irq_gated", {31'b0, irq}, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_ipu_en", {31'b0, ipu_en}, 32'h0);
    rd_chk("arst_status", A_STAT, 32'h0);
    rd_chk("arst_ctrl", A_CTRL, 32'h0000_0840);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
